bus_delay_line: RTL and testbench

Programmable-depth delay line for a WIDTH-bit bus with per-word valid tracking, stall (enable), run-time delay reconfiguration and flush. It replaces fixed-delay per-bit shift chains wherever a datapath bus must be realigned against a control path whose latency is only known at configuration time, e.g. ALU-result vs. writeback alignment in the 8-bit core. Stages hold only when the line is stalled, so a stalled pipeline never loses or duplicates a word.

---
 rtl/bus_delay_pkg.sv | 18 +
 rtl/bus_delay_line_delay_stage.sv | 43 ++++
 rtl/bus_delay_line.sv | 144 ++++++++++++++
 tb/tb_bus_delay_line.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_delay_pkg
// Purpose  : Shared constants and helpers for the programmable bus delay line.
// Revision : 1.0 - initial release
// ============================================================================
package bus_delay_pkg;

    // Every data bit of a stage clears to this value on reset.
    localparam logic c_reset_data_bit = 1'b0;

    // Width of a field able to hold any delay from 0 to max_delay inclusive.
    function automatic int calc_dw(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

endpackage : bus_delay_pkg
`default_nettype wire

// File: rtl/bus_delay_line_delay_stage.sv
`default_nettype none
// ============================================================================
// Module   : delay_stage
// Purpose  : One {valid, data} register of the delay line with advance/hold
//            and a synchronous valid clear used for flushing.
// Revision : 1.0 - initial release
// ============================================================================
module delay_stage
    import bus_delay_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A flush drops only the valid flag; stale data stays visible on the tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {WIDTH{c_reset_data_bit}};
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (shift_en) begin
            r_valid <= d_valid;
            r_data  <= d_data;
        end
    end

    assign q_valid = r_valid;
    assign q_data  = r_data;

endmodule : delay_stage
`default_nettype wire

// File: rtl/bus_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : bus_delay_line
// Purpose  : Programmable-depth bus delay line with valid tracking, stall,
//            run-time delay reload/flush and reload error reporting.
//            Optional occupancy output enabled by BUS_DELAY_OCCUPANCY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_delay_line
    import bus_delay_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 4,
    parameter int DW            = calc_dw(MAX_DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cfg_load,
    input  logic [DW-1:0]    cfg_delay,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [DW-1:0]    cur_delay,
    output logic             cfg_err
`ifdef BUS_DELAY_OCCUPANCY_EN
    ,
    output logic [DW-1:0]    occupancy
`endif
);

    generate
        if (DEFAULT_DELAY > MAX_DELAY || DEFAULT_DELAY < 0) begin : g_chk_default
            $error("bus_delay_line: DEFAULT_DELAY must lie in 0..MAX_DELAY");
        end
        if (WIDTH < 1 || MAX_DELAY < 1) begin : g_chk_size
            $error("bus_delay_line: WIDTH and MAX_DELAY must be >= 1");
        end
    endgenerate

    logic [DW-1:0]    r_cur_delay;
    logic             r_cfg_err;
    logic             w_cfg_ok;
    logic             w_accept;
    logic             w_shift;
    logic             w_tap_valid;
    logic [WIDTH-1:0] w_tap_data;
    logic             w_raw_valid;

    // Index 0 is the live input; index k is the output of stage k.
    logic             w_sv [0:MAX_DELAY];
    logic [WIDTH-1:0] w_sd [0:MAX_DELAY];

    assign w_cfg_ok = (cfg_delay <= DW'(MAX_DELAY));
    assign w_accept = cfg_load & w_cfg_ok;
    // A rejected reload must not disturb the stream, so only accepted ones stall.
    assign w_shift  = en & ~w_accept;

    assign w_sv[0] = in_valid;
    assign w_sd[0] = in_data;

    generate
        for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_stage
            delay_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .shift_en (w_shift),
                .flush    (w_accept),
                .d_valid  (w_sv[k-1]),
                .d_data   (w_sd[k-1]),
                .q_valid  (w_sv[k]),
                .q_data   (w_sd[k])
            );
        end
    endgenerate

    always_comb begin
        w_tap_valid = 1'b0;
        w_tap_data  = {WIDTH{c_reset_data_bit}};
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (r_cur_delay == DW'(k)) begin
                w_tap_valid = w_sv[k];
                w_tap_data  = w_sd[k];
            end
        end
    end

    always_comb begin
        w_raw_valid = w_tap_valid;
        out_data    = w_tap_data;
        if (r_cur_delay == '0) begin
            w_raw_valid = in_valid;
            out_data    = in_data;
        end
    end

    // Words leave only on advancing cycles, and never while a reload flushes.
    assign out_valid = w_raw_valid & en & ~w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_delay <= DW'(DEFAULT_DELAY);
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= cfg_load & ~w_cfg_ok;
            if (w_accept) begin
                r_cur_delay <= cfg_delay;
            end
        end
    end

    assign cur_delay = r_cur_delay;
    assign cfg_err   = r_cfg_err;

`ifdef BUS_DELAY_OCCUPANCY_EN
    logic [DW-1:0] r_occupancy;
    logic          w_occ_inc;
    logic          w_occ_dec;
    logic          w_tap_active;

    assign w_tap_active = (r_cur_delay != '0);
    // A word entering alongside a rejected reload is still in flight, so count it.
    assign w_occ_inc    = w_shift & in_valid & w_tap_active;
    assign w_occ_dec    = out_valid & w_tap_active;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_occupancy <= '0;
        end else if (w_occ_inc && !w_occ_dec) begin
            r_occupancy <= r_occupancy + 1'b1;
        end else if (w_occ_dec && !w_occ_inc) begin
            r_occupancy <= r_occupancy - 1'b1;
        end
    end

    assign occupancy = r_occupancy;
`endif

endmodule : bus_delay_line
`default_nettype wire

// File: tb/tb_bus_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_delay_line
// Purpose  : Self-checking bench for bus_delay_line: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_delay_line;

    localparam int WIDTH = 10;
    localparam int MAXD  = 8;
    localparam int DEFD  = 4;
    localparam int DW    = 4;

    logic             clk = 1'b0;
    logic             rst, en, in_valid, cfg_load;
    logic [WIDTH-1:0] in_data;
    logic [DW-1:0]    cfg_delay;
    logic             out_valid, cfg_err;
    logic [WIDTH-1:0] out_data;
    logic [DW-1:0]    cur_delay;
`ifdef BUS_DELAY_OCCUPANCY_EN
    logic [DW-1:0]    occupancy;
`endif

    bus_delay_line #(
        .WIDTH         (WIDTH),
        .MAX_DELAY     (MAXD),
        .DEFAULT_DELAY (DEFD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cur_delay (cur_delay),
        .cfg_err   (cfg_err)
`ifdef BUS_DELAY_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    always #5 clk = ~clk;

    // Reference: history of the words offered on each advancing cycle, newest last.
    typedef struct {
        bit               v;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t             hist[$];
    int               m_cur;
    bit               m_err;
    int               checks = 0;
    int               errors = 0;
    bit               chk_on = 0;
    bit               collect = 0;
    logic [WIDTH-1:0] emitted[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ent_t z;
        z.v = 1'b0;
        z.d = '0;
        hist.delete();
        for (int i = 0; i < MAXD; i++) hist.push_back(z);
        m_cur = DEFD;
        m_err = 1'b0;
    endtask

    task automatic tick();
        bit               accept;
        bit               ev;
        logic [WIDTH-1:0] ed;
        ent_t             e;
        int               inflight;
        @(negedge clk);
        accept = cfg_load && (int'(cfg_delay) <= MAXD);
        if (m_cur == 0) begin
            ev = in_valid & en;
            ed = in_data;
        end else begin
            ev = hist[MAXD - m_cur].v & en;
            ed = hist[MAXD - m_cur].d;
        end
        if (accept) ev = 1'b0;
        inflight = 0;
        for (int k = 1; k <= m_cur; k++) if (hist[MAXD - k].v) inflight++;
        if (chk_on) begin
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("out_data", 32'(out_data), 32'(ed));
            chk("cur_delay", 32'(cur_delay), 32'(m_cur));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef BUS_DELAY_OCCUPANCY_EN
            chk("occupancy", 32'(occupancy), 32'(inflight));
`endif
        end
        if (collect && out_valid) emitted.push_back(out_data);
        if (rst) begin
            model_reset();
        end else begin
            m_err = cfg_load && !accept;
            if (accept) begin
                m_cur = int'(cfg_delay);
                foreach (hist[i]) hist[i].v = 1'b0;
            end else if (en) begin
                e.v = in_valid;
                e.d = in_data;
                hist.push_back(e);
                void'(hist.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit e, input bit iv, input logic [WIDTH-1:0] id,
                         input bit cl, input logic [DW-1:0] cd);
        rst = r; en = e; in_valid = iv; in_data = id; cfg_load = cl; cfg_delay = cd;
        tick();
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 32'(emitted.size()), 32'd10);
        for (int i = 0; i < 10 && i < emitted.size(); i++)
            chk(tag, 32'(emitted[i]), 32'(i + 1));
    endtask

    initial begin
        model_reset();
        drive(1, 0, 0, '0, 0, '0);
        chk_on = 1;
        drive(1, 0, 0, '0, 0, '0);

        // Straight stream 1..10 at the default delay.
        emitted.delete();
        collect = 1;
        for (int i = 1; i <= 10; i++) drive(0, 1, 1, WIDTH'(i), 0, '0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, '0, 0, '0);
        collect = 0;
        check_stream("stream_plain");

        // Same stream with stalls on cycles 2 and 5.
        emitted.delete();
        collect = 1;
        begin
            int w = 1;
            for (int c = 0; w <= 10; c++) begin
                if (c == 2 || c == 5) drive(0, 0, 1, WIDTH'(w), 0, '0);
                else begin
                    drive(0, 1, 1, WIDTH'(w), 0, '0);
                    w++;
                end
            end
        end
        for (int i = 0; i < 8; i++) drive(0, 1, 0, '0, 0, '0);
        collect = 0;
        check_stream("stream_stall");

        // Zero-delay bypass, then maximum delay.
        drive(0, 1, 0, '0, 1, 4'd0);
        drive(0, 1, 1, 10'h155, 0, '0);
        drive(0, 1, 0, '0, 1, 4'd8);
        drive(0, 1, 1, 10'h2AA, 0, '0);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, '0, 0, '0);

        // Rejected reload mid-stream at delay 4.
        drive(0, 1, 0, '0, 1, 4'd4);
        for (int i = 0; i < 3; i++) drive(0, 1, 1, WIDTH'(10'h30 + i), 0, '0);
        drive(0, 1, 1, 10'h33, 1, 4'd9);
        for (int i = 0; i < 6; i++) drive(0, 1, 1, WIDTH'(10'h34 + i), 0, '0);

        // Reload with words in flight, then a fresh word.
        drive(0, 1, 0, '0, 1, 4'd2);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, '0, 0, '0);
        drive(0, 1, 1, 10'h0AB, 0, '0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, '0, 0, '0);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) drive(0, 1, 1, WIDTH'(10'h3C0 + i), 0, '0);
        drive(1, 1, 1, 10'h3FF, 0, '0);
        for (int i = 0; i < 6; i++) drive(0, 1, 1, WIDTH'(10'h100 + i), 0, '0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit r, e, iv, cl;
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 80);
            iv = ($urandom_range(0, 99) < 70);
            cl = ($urandom_range(0, 99) < 5);
            drive(r, e, iv, WIDTH'($urandom_range(0, 1023)), cl, DW'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bus_delay_line
`default_nettype wire
